ms_dbg_mem_arb: RTL and testbench
=================================

MS_DBG_MEM_ARB -- requirements
Module: ms_dbg_mem_arb

Interface
REQ-001 Parameter CDbgPrio, default 1: 1 = debug request wins over the CPU immediately; 0 = debug waits for a CPU-idle cycle or starvation timeout.
REQ-002 Parameter CMaxWait, default 4: maximum enabled cycles a debug request waits when CDbgPrio=0, range 1..15.
REQ-003 AClkH  in  1  single clock.
REQ-004 AResetHN  in  1  reset, asynchronous, active-low.
REQ-005 AClkHEn  in  1  clock enable; state advances only when 1.
REQ-006 ADbgMemAccess  in  1  debug unit owns its memory port.
REQ-007 ADbgMemAddr  in  29  debug qword address [31:3].
REQ-008 ADbgMemMosi  in  64  debug write data.
REQ-009 ADbgMemWrRdEn  in  2  debug strobes: bit1 = write, bit0 = read.
REQ-010 ADbgMemMiso  out  64  registered debug read data.
REQ-011 ADbgBusy  out  1  debug request pending or read in flight.
REQ-012 ADbgOvf  out  1  sticky flag: a debug request was dropped.
REQ-013 ACpuAddr / ACpuMosi / ACpuWrEn / ACpuRdEn  in  29/64/8/1  CPU request (byte write enables, read strobe).
REQ-014 ACpuMiso / ACpuStall  out  64/1  CPU read data and stall.
REQ-015 AMemAddr / AMemMosi / AMemWrEn / AMemRdEn  out  29/64/8/1  shared RAM port.
REQ-016 AMemMiso  in  64  RAM read data, valid exactly 1 cycle after AMemRdEn.

Function
REQ-017 A debug request SHALL be captured when AClkHEn=1, ADbgMemAccess=1 and ADbgMemWrRdEn!=0; address, data and operation are latched into a pending slot.
REQ-018 ADbgMemWrRdEn=2'b11 SHALL be treated as a write only.
REQ-019 A new debug request arriving while the slot is pending or a read is in flight SHALL be dropped, and ADbgOvf SHALL set (cleared only by reset).
REQ-020 FSM states: IDLE, PEND, ISSUE, RDWAIT; transitions occur only on enabled cycles.
REQ-021 IDLE->PEND on capture; if CDbgPrio=1, PEND->ISSUE on the next enabled cycle unconditionally.
REQ-022 If CDbgPrio=0, PEND->ISSUE when ACpuWrEn==0 and ACpuRdEn==0, or when the 4-bit wait counter reaches CMaxWait; the counter clears on entry to PEND.
REQ-023 In ISSUE, the memory port SHALL carry the debug request: write uses AMemWrEn=8'hFF; read uses AMemRdEn=1.
REQ-024 ISSUE->IDLE after a write; ISSUE->RDWAIT after a read.
REQ-025 RDWAIT: ADbgMemMiso<=AMemMiso, then ->IDLE; ADbgMemMiso holds until the next debug read completes.
REQ-026 ACpuStall SHALL be combinational: 1 in ISSUE when a CPU strobe is active, otherwise 0; a stalled CPU holds its request.
REQ-027 Outside ISSUE, the memory port SHALL pass the CPU request through combinationally.
REQ-028 ACpuMiso SHALL be AMemMiso passthrough; a CPU read in cycle N followed by ISSUE in N+1 is legal (pipelined).
REQ-029 AClkHEn=0 SHALL force AMemWrEn=0 and AMemRdEn=0, freeze the FSM and counter, and capture nothing.
REQ-030 ADbgBusy SHALL be 1 in PEND, ISSUE and RDWAIT.

Reset
REQ-031 Reset asserted SHALL immediately set: FSM=IDLE, pending slot cleared, counter=0, ADbgMemMiso=0, ADbgOvf=0, ADbgBusy=0.
REQ-032 Reset mid-operation SHALL drop any pending or in-flight debug access without completing it; no capture follows.

Verification
REQ-033 CDbgPrio=1, CPU reading continuously; debug read at addr 0x100, RAM returns 0xDEADBEEF_CAFEF00D -> ISSUE 1 cycle after capture, ACpuStall=1 for 1 cycle, ADbgMemMiso=0xDEADBEEF_CAFEF00D 2 cycles after ISSUE, ADbgBusy drops.
REQ-034 CDbgPrio=0, CMaxWait=4, CPU never idle; debug write -> AMemWrEn=8'hFF exactly 4 enabled cycles after entering PEND.
REQ-035 Second debug request while PEND -> request dropped, ADbgOvf=1 and stays 1; first request still completes.
REQ-036 AClkHEn toggling 1/0 during a debug read -> memory strobes 0 on disabled cycles; result identical to the always-enabled run.
REQ-037 AResetHN pulsed low in RDWAIT -> all outputs return to reset values at once; ADbgMemMiso=0; no late capture after reset releases.

Source files
------------

// File: rtl/ms_dbg_mem_arb.sv
// Arbiter sharing one single-port RAM between the CPU and a debug unit.
// Debug accesses sit in a one-deep slot and are slipped into the CPU stream.
module ms_dbg_mem_arb #(
    parameter bit          CDbgPrio = 1'b1,
    parameter int unsigned CMaxWait = 4
) (
    input  logic        AClkH,
    input  logic        AResetHN,
    input  logic        AClkHEn,
    input  logic        ADbgMemAccess,
    input  logic [28:0] ADbgMemAddr,
    input  logic [63:0] ADbgMemMosi,
    input  logic [1:0]  ADbgMemWrRdEn,
    output logic [63:0] ADbgMemMiso,
    output logic        ADbgBusy,
    output logic        ADbgOvf,
    input  logic [28:0] ACpuAddr,
    input  logic [63:0] ACpuMosi,
    input  logic [7:0]  ACpuWrEn,
    input  logic        ACpuRdEn,
    output logic [63:0] ACpuMiso,
    output logic        ACpuStall,
    output logic [28:0] AMemAddr,
    output logic [63:0] AMemMosi,
    output logic [7:0]  AMemWrEn,
    output logic        AMemRdEn,
    input  logic [63:0] AMemMiso
);

    localparam int unsigned AddrW = 29;
    localparam int unsigned DataW = 64;
    localparam int unsigned CntW  = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PEND   = 2'd1,
        S_ISSUE  = 2'd2,
        S_RDWAIT = 2'd3
    } state_t;

    state_t             state;
    logic [AddrW-1:0]   slot_addr;
    logic [DataW-1:0]   slot_data;
    logic               slot_wr;
    logic [CntW-1:0]    wait_cnt;

    logic dbg_req_c;
    logic cpu_act_c;
    logic wait_done_c;

    assign dbg_req_c   = AClkHEn & ADbgMemAccess & (|ADbgMemWrRdEn);
    assign cpu_act_c   = (|ACpuWrEn) | ACpuRdEn;
    assign wait_done_c = (CntW'(wait_cnt + CntW'(1)) == CntW'(CMaxWait));

    // Debug slot sequencing; every transition is gated by the clock enable.
    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            state       <= S_IDLE;
            slot_addr   <= '0;
            slot_data   <= '0;
            slot_wr     <= 1'b0;
            wait_cnt    <= '0;
            ADbgMemMiso <= '0;
            ADbgBusy    <= 1'b0;
            ADbgOvf     <= 1'b0;
        end else if (AClkHEn) begin
            // Any request landing while the slot is occupied is lost.
            if (dbg_req_c && (state != S_IDLE)) begin
                ADbgOvf <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (dbg_req_c) begin
                        slot_addr <= ADbgMemAddr;
                        slot_data <= ADbgMemMosi;
                        slot_wr   <= ADbgMemWrRdEn[1];
                        wait_cnt  <= '0;
                        ADbgBusy  <= 1'b1;
                        state     <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (CDbgPrio || !cpu_act_c || wait_done_c) begin
                        state <= S_ISSUE;
                    end else begin
                        wait_cnt <= CntW'(wait_cnt + CntW'(1));
                    end
                end
                S_ISSUE: begin
                    if (slot_wr) begin
                        ADbgBusy <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        state <= S_RDWAIT;
                    end
                end
                S_RDWAIT: begin
                    ADbgMemMiso <= AMemMiso;
                    ADbgBusy    <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    ADbgBusy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    // RAM port mux: debug owns the port only in ISSUE, strobes die when disabled.
    always_comb begin
        AMemAddr  = ACpuAddr;
        AMemMosi  = ACpuMosi;
        AMemWrEn  = ACpuWrEn;
        AMemRdEn  = ACpuRdEn;
        ACpuStall = 1'b0;
        if (state == S_ISSUE) begin
            AMemAddr  = slot_addr;
            AMemMosi  = slot_data;
            AMemWrEn  = slot_wr ? 8'hFF : 8'h00;
            AMemRdEn  = ~slot_wr;
            ACpuStall = cpu_act_c;
        end
        if (!AClkHEn) begin
            AMemWrEn = 8'h00;
            AMemRdEn = 1'b0;
        end
    end

    assign ACpuMiso = AMemMiso;

endmodule

// File: tb/tb_ms_dbg_mem_arb.sv
// Bench for ms_dbg_mem_arb: a priority and a wait-limited instance share the
// same stimulus, each backed by its own behavioural RAM and transaction model.
module tb_ms_dbg_mem_arb;

    localparam int NInst   = 2;
    localparam int MaxWait = 4;
    localparam int PhWait  = 0;
    localparam int PhMem   = 1;
    localparam int PhData  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        dbg_acc;
    logic [28:0] dbg_addr;
    logic [63:0] dbg_mosi;
    logic [1:0]  dbg_wrrd;
    logic [28:0] cpu_addr;
    logic [63:0] cpu_mosi;
    logic [7:0]  cpu_wr;
    logic        cpu_rd;

    logic [63:0] dbg_miso  [NInst];
    logic        dbg_busy  [NInst];
    logic        dbg_ovf   [NInst];
    logic [63:0] cpu_miso  [NInst];
    logic        cpu_stall [NInst];
    logic [28:0] mem_addr  [NInst];
    logic [63:0] mem_mosi  [NInst];
    logic [7:0]  mem_wr    [NInst];
    logic        mem_rd    [NInst];
    logic [63:0] ram_q     [NInst];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NInst; g++) begin : g_dut
        ms_dbg_mem_arb #(
            .CDbgPrio (g == 0),
            .CMaxWait (MaxWait)
        ) u_dut (
            .AClkH         (clk),
            .AResetHN      (rst_n),
            .AClkHEn       (clk_en),
            .ADbgMemAccess (dbg_acc),
            .ADbgMemAddr   (dbg_addr),
            .ADbgMemMosi   (dbg_mosi),
            .ADbgMemWrRdEn (dbg_wrrd),
            .ADbgMemMiso   (dbg_miso[g]),
            .ADbgBusy      (dbg_busy[g]),
            .ADbgOvf       (dbg_ovf[g]),
            .ACpuAddr      (cpu_addr),
            .ACpuMosi      (cpu_mosi),
            .ACpuWrEn      (cpu_wr),
            .ACpuRdEn      (cpu_rd),
            .ACpuMiso      (cpu_miso[g]),
            .ACpuStall     (cpu_stall[g]),
            .AMemAddr      (mem_addr[g]),
            .AMemMosi      (mem_mosi[g]),
            .AMemWrEn      (mem_wr[g]),
            .AMemRdEn      (mem_rd[g]),
            .AMemMiso      (ram_q[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural RAM: 16 words aliased by address, read data one cycle after the strobe.
    logic [63:0] ram     [NInst][16];
    bit          ram_wrt [NInst][16];
    logic [28:0] l_addr  [NInst];
    logic [63:0] l_mosi  [NInst];
    logic [7:0]  l_wr    [NInst];
    logic        l_rd    [NInst];

    function automatic logic [63:0] ram_default(input int idx);
        if (idx == 0) return 64'hDEAD_BEEF_CAFE_F00D;
        return {16'hA5A5, 16'(idx), 16'h5A5A, ~16'(idx)};
    endfunction

    function automatic logic [63:0] ram_rd(input int m, input logic [28:0] a);
        int i;
        i = int'(a[3:0]);
        return ram_wrt[m][i] ? ram[m][i] : ram_default(i);
    endfunction

    function automatic logic [63:0] merge_bytes(input logic [63:0] old, input logic [63:0] nw,
                                                input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < NInst; m++) begin
            if (l_rd[m]) ram_q[m] <= ram_rd(m, l_addr[m]);
            if (l_wr[m] != 8'h00) begin
                ram[m][int'(l_addr[m][3:0])]     <= merge_bytes(ram_rd(m, l_addr[m]), l_mosi[m], l_wr[m]);
                ram_wrt[m][int'(l_addr[m][3:0])] <= 1'b1;
            end
        end
    end

    // Transaction model: one outstanding debug access and what the debug side observes.
    typedef struct {
        bit          valid;
        bit          wr;
        logic [28:0] addr;
        logic [63:0] data;
        int          waited;
        int          phase;
        logic [63:0] rdata;
        logic [63:0] miso;
        bit          ovf;
    } txn_t;

    txn_t mdl [NInst];

    function automatic txn_t txn_reset();
        txn_t t;
        t = '{default: 0};
        return t;
    endfunction

    function automatic txn_t model_step(input txn_t cur, input bit prio, input bit req,
                                        input bit cpu_busy, input logic [63:0] mem_word,
                                        input bit op_wr, input logic [28:0] a,
                                        input logic [63:0] d);
        txn_t n;
        n = cur;
        if (cur.valid) begin
            if (req) n.ovf = 1'b1;
            if (cur.phase == PhWait) begin
                n.waited = cur.waited + 1;
                if (prio || !cpu_busy || n.waited >= MaxWait) n.phase = PhMem;
            end else if (cur.phase == PhMem) begin
                if (cur.wr) begin
                    n.valid = 1'b0;
                end else begin
                    n.rdata = mem_word;
                    n.phase = PhData;
                end
            end else begin
                n.miso  = cur.rdata;
                n.valid = 1'b0;
            end
        end else if (req) begin
            n.valid  = 1'b1;
            n.wr     = op_wr;
            n.addr   = a;
            n.data   = d;
            n.waited = 0;
            n.phase  = PhWait;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < NInst; m++) mdl[m] <= txn_reset();
        end else if (clk_en) begin
            for (int m = 0; m < NInst; m++) begin
                mdl[m] <= model_step(mdl[m], m == 0, dbg_acc && (dbg_wrrd != 2'b00),
                                     (cpu_wr != 8'h00) || cpu_rd, ram_rd(m, mdl[m].addr),
                                     dbg_wrrd[1], dbg_addr, dbg_mosi);
            end
        end
    end

    // Mid-cycle comparison of every output against the model; also feeds the RAM.
    always @(negedge clk) begin
        for (int m = 0; m < NInst; m++) begin
            l_addr[m] <= mem_addr[m];
            l_mosi[m] <= mem_mosi[m];
            l_wr[m]   <= mem_wr[m];
            l_rd[m]   <= mem_rd[m];
        end
        if (chk_on) begin
            for (int m = 0; m < NInst; m++) begin
                bit          iss;
                logic [7:0]  e_wr;
                logic        e_rd;
                iss  = mdl[m].valid && (mdl[m].phase == PhMem);
                e_wr = !clk_en ? 8'h00 : (iss ? (mdl[m].wr ? 8'hFF : 8'h00) : cpu_wr);
                e_rd = clk_en && (iss ? !mdl[m].wr : cpu_rd);
                check($sformatf("busy%0d", m), 64'(dbg_busy[m]), 64'(mdl[m].valid));
                check($sformatf("ovf%0d", m), 64'(dbg_ovf[m]), 64'(mdl[m].ovf));
                check($sformatf("dbg_miso%0d", m), dbg_miso[m], mdl[m].miso);
                check($sformatf("stall%0d", m), 64'(cpu_stall[m]),
                      64'(iss && ((cpu_wr != 8'h00) || cpu_rd)));
                check($sformatf("mem_addr%0d", m), 64'(mem_addr[m]), 64'(iss ? mdl[m].addr : cpu_addr));
                check($sformatf("mem_mosi%0d", m), mem_mosi[m], iss ? mdl[m].data : cpu_mosi);
                check($sformatf("mem_wr%0d", m), 64'(mem_wr[m]), 64'(e_wr));
                check($sformatf("mem_rd%0d", m), 64'(mem_rd[m]), 64'(e_rd));
                check($sformatf("cpu_miso%0d", m), cpu_miso[m], ram_q[m]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit en, input bit acc, input logic [1:0] wrrd,
                         input logic [28:0] da, input logic [63:0] dd,
                         input bit crd, input logic [7:0] cwr);
        clk_en   = en;
        dbg_acc  = acc;
        dbg_wrrd = wrrd;
        dbg_addr = da;
        dbg_mosi = dd;
        cpu_rd   = crd;
        cpu_wr   = cwr;
    endtask

    initial begin
        bit en;
        rst_n    = 1'b1;
        cpu_addr = 29'h55;
        cpu_mosi = 64'h0123_4567_89AB_CDEF;
        drive(1'b0, 1'b0, 2'b00, 29'h0, 64'h0, 1'b0, 8'h00);
        #1 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        repeat (3) tick();
        for (int m = 0; m < NInst; m++) begin
            check($sformatf("rst_busy%0d", m), 64'(dbg_busy[m]), 64'd0);
            check($sformatf("rst_ovf%0d", m), 64'(dbg_ovf[m]), 64'd0);
            check($sformatf("rst_miso%0d", m), dbg_miso[m], 64'd0);
        end
        rst_n = 1'b1;

        // Priority debug read while the CPU reads every cycle.
        drive(1'b1, 1'b1, 2'b01, 29'h100, 64'h0, 1'b1, 8'h00);
        #1 check("prio_cap_busy", 64'(dbg_busy[0]), 64'd0);
        tick();
        drive(1'b1, 1'b0, 2'b00, 29'h0, 64'h0, 1'b1, 8'h00);
        #1 check("prio_pend_busy", 64'(dbg_busy[0]), 64'd1);
        check("prio_pend_addr", 64'(mem_addr[0]), 64'h55);
        check("prio_pend_stall", 64'(cpu_stall[0]), 64'd0);
        tick();
        #1 check("prio_issue_addr", 64'(mem_addr[0]), 64'h100);
        check("prio_issue_rd", 64'(mem_rd[0]), 64'd1);
        check("prio_issue_stall", 64'(cpu_stall[0]), 64'd1);
        tick();
        #1 check("prio_rdwait_stall", 64'(cpu_stall[0]), 64'd0);
        check("prio_rdwait_busy", 64'(dbg_busy[0]), 64'd1);
        tick();
        #1 check("prio_rdata", dbg_miso[0], 64'hDEAD_BEEF_CAFE_F00D);
        check("prio_done_busy", 64'(dbg_busy[0]), 64'd0);
        drive(1'b1, 1'b0, 2'b00, 29'h0, 64'h0, 1'b0, 8'h00);
        repeat (8) tick();

        // Debug write against a CPU that never goes idle.
        drive(1'b1, 1'b1, 2'b10, 29'h2A, 64'h1122_3344_5566_7788, 1'b1, 8'h00);
        tick();
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 1'b0, 2'b00, 29'h0, 64'h0, 1'b1, 8'h00);
            #1 check($sformatf("starve_wr1_k%0d", k), 64'(mem_wr[1]), 64'((k == 5) ? 8'hFF : 8'h00));
            check($sformatf("starve_wr0_k%0d", k), 64'(mem_wr[0]), 64'((k == 2) ? 8'hFF : 8'h00));
            tick();
        end
        drive(1'b1, 1'b0, 2'b00, 29'h0, 64'h0, 1'b0, 8'h00);
        repeat (4) tick();

        // Overlapping request is dropped; the first (write-only via 2'b11) still lands.
        drive(1'b1, 1'b1, 2'b11, 29'h33, 64'hCAFE_0000_1234_5678, 1'b1, 8'h00);
        tick();
        drive(1'b1, 1'b1, 2'b01, 29'h44, 64'h0, 1'b1, 8'h00);
        #1 check("ovf0_before", 64'(dbg_ovf[0]), 64'd0);
        check("ovf1_before", 64'(dbg_ovf[1]), 64'd0);
        tick();
        for (int k = 2; k <= 7; k++) begin
            drive(1'b1, 1'b0, 2'b00, 29'h0, 64'h0, 1'b1, 8'h00);
            #1 check("ovf0_set", 64'(dbg_ovf[0]), 64'd1);
            check("ovf1_set", 64'(dbg_ovf[1]), 64'd1);
            if (k == 5) begin
                check("ovf_first_wr", 64'(mem_wr[1]), 64'hFF);
                check("ovf_first_rd", 64'(mem_rd[1]), 64'd0);
                check("ovf_first_addr", 64'(mem_addr[1]), 64'h33);
                check("ovf_first_data", mem_mosi[1], 64'hCAFE_0000_1234_5678);
            end
            tick();
        end
        drive(1'b1, 1'b0, 2'b00, 29'h0, 64'h0, 1'b0, 8'h00);
        repeat (4) tick();
        check("ovf0_sticky", 64'(dbg_ovf[0]), 64'd1);
        check("ovf1_sticky", 64'(dbg_ovf[1]), 64'd1);

        // Debug read with the clock enable toggling every cycle.
        drive(1'b1, 1'b1, 2'b01, 29'h33, 64'h0, 1'b1, 8'h00);
        tick();
        for (int k = 1; k <= 20; k++) begin
            en = (k % 2) == 0;
            drive(en, 1'b0, 2'b00, 29'h0, 64'h0, 1'b1, 8'h00);
            #1;
            if (!en) begin
                for (int m = 0; m < NInst; m++) begin
                    check($sformatf("gate_wr%0d", m), 64'(mem_wr[m]), 64'd0);
                    check($sformatf("gate_rd%0d", m), 64'(mem_rd[m]), 64'd0);
                end
            end
            tick();
        end
        check("gate_rdata0", dbg_miso[0], 64'hCAFE_0000_1234_5678);
        check("gate_rdata1", dbg_miso[1], 64'hCAFE_0000_1234_5678);

        // Reset pulse while the read is waiting for its data.
        drive(1'b1, 1'b1, 2'b01, 29'h2A, 64'h0, 1'b0, 8'h00);
        tick();
        drive(1'b1, 1'b0, 2'b00, 29'h0, 64'h0, 1'b0, 8'h00);
        tick();
        #1 check("rst_issue_addr", 64'(mem_addr[0]), 64'h2A);
        tick();
        #1 check("rst_rdwait_busy", 64'(dbg_busy[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < NInst; m++) begin
            check($sformatf("async_busy%0d", m), 64'(dbg_busy[m]), 64'd0);
            check($sformatf("async_miso%0d", m), dbg_miso[m], 64'd0);
            check($sformatf("async_ovf%0d", m), 64'(dbg_ovf[m]), 64'd0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 check("post_rst_busy0", 64'(dbg_busy[0]), 64'd0);
            check("post_rst_miso0", dbg_miso[0], 64'd0);
            tick();
        end

        // Randomized traffic, with an occasional asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            clk_en   = $urandom_range(0, 3) != 0;
            dbg_acc  = $urandom_range(0, 9) == 0;
            dbg_wrrd = 2'($urandom_range(0, 3));
            dbg_addr = 29'($urandom);
            dbg_mosi = {$urandom, $urandom};
            cpu_rd   = $urandom_range(0, 1) == 1;
            cpu_wr   = (!cpu_rd && ($urandom_range(0, 2) == 0)) ? 8'($urandom) : 8'h00;
            cpu_addr = 29'($urandom);
            cpu_mosi = {$urandom, $urandom};
            if (i % 700 == 699) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
